// File: rtl/wwd_result_checker_pkg.sv
// checker_pkg: shared state encoding and default sizing for the WWD result checker
package checker_pkg;
  localparam int DEF_WORD_SIZE = 16;
  localparam int DEF_NUM_TEST = 56;
  localparam int DEF_MAX_CYCLES = 10000;
  typedef enum logic [1:0] {RUN, FINALIZE, DONE} state_e;
endpackage

// File: rtl/wwd_result_checker_if.sv
// wwd_result_checker_if: cpu debug outputs plus expected-result ROM read port
// master = checker (drives tbl_idx); slave = cpu/ROM side (drives everything else)
interface wwd_result_checker_if
  import checker_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int IDX_W = 6
);
  logic [WORD_SIZE-1:0] num_inst;
  logic [WORD_SIZE-1:0] output_port;
  logic is_halted;
  logic [IDX_W-1:0] tbl_idx;
  logic [WORD_SIZE-1:0] tbl_num_inst;
  logic [WORD_SIZE-1:0] tbl_ans;
  modport master(output tbl_idx, input num_inst, input output_port, input is_halted, input tbl_num_inst, input tbl_ans);
  modport slave(input tbl_idx, output num_inst, output output_port, output is_halted, output tbl_num_inst, output tbl_ans);
endinterface

// File: rtl/wwd_result_checker_sat_counter.sv
// sat_counter: synchronous-clear up counter that sticks at all-ones
// ports: clk, clr_i (sync clear, wins over inc), inc_i, q_o (count)
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] q_q;
  always_ff @(posedge clk)
    q_q <= clr_i ? '0 : (inc_i && !(&q_q)) ? q_q + W'(1) : q_q;
  assign q_o = q_q;
endmodule

// File: rtl/wwd_result_checker.sv
// wwd_result_checker: compares cpu WWD output against an ordered expected-result table and tallies pass/miss/fail
// ports: clk, reset (sync, active-high), bus (cpu debug + table ROM), done/all_pass/failed/timeout flags,
// fail_idx/fail_value (first failure), pass_count/miss_count/num_clock tallies
module wwd_result_checker
  import checker_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int NUM_TEST = DEF_NUM_TEST,
  parameter int IDX_W = 6,
  parameter int MAX_CYCLES = DEF_MAX_CYCLES,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  wwd_result_checker_if.master bus,
  output logic                 done,
  output logic                 all_pass,
  output logic                 failed,
  output logic                 timeout,
  output logic [IDX_W-1:0]     fail_idx,
  output logic [WORD_SIZE-1:0] fail_value,
  output logic [CNT_W-1:0]     pass_count,
  output logic [CNT_W-1:0]     miss_count,
  output logic [CNT_W-1:0]     num_clock
);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_TEST);
  state_e state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d, fail_idx_q, fail_idx_d;
  logic [WORD_SIZE-1:0] fail_value_q, fail_value_d;
  logic seen_q, seen_d, failed_q, failed_d, timeout_q, timeout_d;
  logic clk_inc, pass_inc, miss_inc;
  logic in_tbl, hit, mism, late, skip;
  assign in_tbl = ptr_q < LAST;
  assign hit = in_tbl && bus.num_inst == bus.tbl_num_inst;
  assign mism = hit && bus.output_port != bus.tbl_ans;
  assign late = in_tbl && bus.num_inst > bus.tbl_num_inst;
  // the entry that failed stays under ptr, so it is the only one excluded from both tallies
  assign skip = failed_q && ptr_q == fail_idx_q;
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    seen_d = seen_q;
    failed_d = failed_q;
    fail_idx_d = fail_idx_q;
    fail_value_d = fail_value_q;
    timeout_d = timeout_q;
    clk_inc = 1'b0;
    pass_inc = 1'b0;
    miss_inc = 1'b0;
    if (state_q == RUN) begin
      clk_inc = 1'b1;
      if (mism) begin
        failed_d = 1'b1;
        fail_idx_d = ptr_q;
        fail_value_d = bus.output_port;
        state_d = FINALIZE;
      end else if (hit) begin
        seen_d = 1'b1;
      end else if (late) begin
        pass_inc = seen_q;
        miss_inc = !seen_q;
        ptr_d = ptr_q + IDX_W'(1);
        seen_d = 1'b0;
      end
      if (bus.is_halted) begin
        state_d = FINALIZE;
      end else if (!mism && num_clock == CNT_W'(MAX_CYCLES - 1)) begin
        timeout_d = 1'b1;
        state_d = FINALIZE;
      end
    end else if (state_q == FINALIZE) begin
      if (in_tbl) begin
        pass_inc = seen_q && !skip;
        miss_inc = !seen_q && !skip;
        ptr_d = ptr_q + IDX_W'(1);
        seen_d = 1'b0;
      end
      state_d = ptr_d == LAST ? DONE : FINALIZE;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      ptr_q <= '0;
      seen_q <= 1'b0;
      failed_q <= 1'b0;
      fail_idx_q <= '0;
      fail_value_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      seen_q <= seen_d;
      failed_q <= failed_d;
      fail_idx_q <= fail_idx_d;
      fail_value_q <= fail_value_d;
      timeout_q <= timeout_d;
    end
  end
  sat_counter #(.W(CNT_W)) u_clk  (.clk(clk), .clr_i(reset), .inc_i(clk_inc),  .q_o(num_clock));
  sat_counter #(.W(CNT_W)) u_pass (.clk(clk), .clr_i(reset), .inc_i(pass_inc), .q_o(pass_count));
  sat_counter #(.W(CNT_W)) u_miss (.clk(clk), .clr_i(reset), .inc_i(miss_inc), .q_o(miss_count));
  assign bus.tbl_idx = ptr_q;
  assign done = state_q == DONE;
  assign all_pass = done && pass_count == CNT_W'(NUM_TEST) && !failed_q;
  assign failed = failed_q;
  assign timeout = timeout_q;
  assign fail_idx = fail_idx_q;
  assign fail_value = fail_value_q;
endmodule

// File: tb/tb_wwd_result_checker.sv
// tb_wwd_result_checker: scoreboard bench for wwd_result_checker with a 3-entry table and 20-cycle budget
module tb_wwd_result_checker;
  localparam int NT = 3;
  localparam int MC = 20;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  logic done, all_pass, failed, timeout;
  logic [5:0] fail_idx;
  logic [15:0] fail_value, pass_count, miss_count, num_clock;
  int checks = 0;
  int failures = 0;
  logic [15:0] rom_n [NT] = '{16'd3, 16'd5, 16'd7};
  typedef struct {
    logic [31:0] pass, miss, fl, fidx, fval, ap, to, nclk;
  } exp_t;
  exp_t sb[$];
  wwd_result_checker_if #(.WORD_SIZE(16), .IDX_W(6)) bus();
  assign bus.tbl_num_inst = bus.tbl_idx < 6'(NT) ? rom_n[bus.tbl_idx[1:0]] : 16'hFFFF;
  assign bus.tbl_ans = bus.tbl_idx < 6'(NT) ? 16'(bus.tbl_idx) : 16'hFFFF;
  wwd_result_checker #(
    .WORD_SIZE(16), .NUM_TEST(NT), .IDX_W(6), .MAX_CYCLES(MC), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .done(done), .all_pass(all_pass), .failed(failed), .timeout(timeout),
    .fail_idx(fail_idx), .fail_value(fail_value),
    .pass_count(pass_count), .miss_count(miss_count), .num_clock(num_clock)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [15:0] good(input int n);
    return (n == 3 || n == 5 || n == 7) ? 16'((n - 3) / 2) : 16'hBEEF;
  endfunction
  task automatic step(input int n, input logic [15:0] p, input logic h);
    bus.num_inst = 16'(n);
    bus.output_port = p;
    bus.is_halted = h;
    @(posedge clk);
    #1;
  endtask
  task automatic push(input int pass, input int miss, input int fl, input int fidx,
                      input int fval, input int ap, input int to, input int nclk);
    exp_t e;
    e.pass = pass; e.miss = miss; e.fl = fl; e.fidx = fidx;
    e.fval = fval; e.ap = ap; e.to = to; e.nclk = nclk;
    sb.push_back(e);
  endtask
  task automatic do_reset(input bit check);
    reset = 1'b1;
    bus.num_inst = '0;
    bus.output_port = '0;
    bus.is_halted = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    if (check) begin
      chk("rst_done", done, 0);
      chk("rst_failed", failed, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_pass", pass_count, 0);
      chk("rst_miss", miss_count, 0);
      chk("rst_nclk", num_clock, 0);
      chk("rst_idx", bus.tbl_idx, 0);
    end
    reset = 1'b0;
  endtask
  task automatic finish_run(input string tag, input int max_lat);
    exp_t e;
    int w = 0;
    while (!done && w < 40) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk({tag, "_done"}, done, 1);
    if (max_lat > 0) chk({tag, "_done_lat"}, 32'(w <= max_lat), 1);
    e = sb.pop_front();
    chk({tag, "_pass"}, pass_count, e.pass);
    chk({tag, "_miss"}, miss_count, e.miss);
    chk({tag, "_failed"}, failed, e.fl);
    if (e.fl != 0) begin
      chk({tag, "_fidx"}, fail_idx, e.fidx);
      chk({tag, "_fval"}, fail_value, e.fval);
    end
    chk({tag, "_allpass"}, all_pass, e.ap);
    chk({tag, "_timeout"}, timeout, e.to);
    chk({tag, "_nclk"}, num_clock, e.nclk);
    chk({tag, "_sum"}, 32'(pass_count) + 32'(miss_count) + 32'(failed), NT);
  endtask
  task automatic run_pass(input string tag);
    push(3, 0, 0, 0, 0, 1, 0, 9);
    for (int n = 0; n <= 8; n++) step(n, good(n), n == 8);
    finish_run(tag, 2);
  endtask
  initial begin
    do_reset(1);
    run_pass("pass");
    do_reset(0);
    push(1, 1, 1, 1, 7, 0, 0, 6);
    for (int n = 0; n <= 4; n++) step(n, good(n), 1'b0);
    step(5, 16'h0007, 1'b0);
    chk("fail_lat", failed, 1);
    finish_run("fail", 0);
    do_reset(0);
    push(0, 3, 0, 0, 0, 0, 0, 4);
    step(2, 16'hBEEF, 1'b0);
    step(9, 16'hBEEF, 1'b0);
    chk("jump_miss1", miss_count, 1);
    step(9, 16'hBEEF, 1'b0);
    chk("jump_miss2", miss_count, 2);
    step(9, 16'hBEEF, 1'b1);
    chk("jump_miss3", miss_count, 3);
    finish_run("jump", 0);
    do_reset(0);
    push(0, 2, 1, 0, 16'h55, 0, 0, 6);
    for (int n = 0; n <= 2; n++) step(n, good(n), 1'b0);
    step(3, 16'h0000, 1'b0);
    step(3, 16'h0000, 1'b0);
    chk("stall_ok", failed, 0);
    step(3, 16'h0055, 1'b0);
    chk("stall_fail", failed, 1);
    finish_run("stall", 0);
    do_reset(0);
    push(1, 2, 0, 0, 0, 0, 1, MC);
    for (int n = 0; n <= 3; n++) step(n, good(n), 1'b0);
    step(4, 16'hBEEF, 1'b0);
    finish_run("tmo", 0);
    do_reset(0);
    for (int n = 0; n <= 4; n++) step(n, good(n), 1'b0);
    chk("mid_pass", pass_count, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_pass", pass_count, 0);
    chk("mid_rst_miss", miss_count, 0);
    chk("mid_rst_nclk", num_clock, 0);
    chk("mid_rst_idx", bus.tbl_idx, 0);
    chk("mid_rst_done", done, 0);
    reset = 1'b0;
    bus.num_inst = '0;
    run_pass("rerun");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
